// File: rtl/mem_to_axilite_bridge.sv
// mem_to_axilite_bridge: converts a core-side MEM req/gnt/valid port into
// AXI4-Lite master transactions, one transaction in flight at a time.
// Optional watchdog enabled by defining BRIDGE_TIMEOUT_EN.
module mem_to_axilite_bridge #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   s_mem_req,
  output logic                   s_mem_gnt,
  input  logic [AddrWidth-1:0]   s_mem_addr,
  input  logic                   s_mem_we,
  input  logic [DataWidth/8-1:0] s_mem_be,
  input  logic [DataWidth-1:0]   s_mem_wdata,
  output logic                   s_mem_valid,
  output logic [DataWidth-1:0]   s_mem_rdata,
  output logic                   s_mem_error,
  output logic                   m_axi_awvalid,
  input  logic                   m_axi_awready,
  output logic [AddrWidth-1:0]   m_axi_awaddr,
  output logic [2:0]             m_axi_awprot,
  output logic                   m_axi_wvalid,
  input  logic                   m_axi_wready,
  output logic [DataWidth-1:0]   m_axi_wdata,
  output logic [DataWidth/8-1:0] m_axi_wstrb,
  input  logic                   m_axi_bvalid,
  output logic                   m_axi_bready,
  input  logic [1:0]             m_axi_bresp,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready,
  output logic [AddrWidth-1:0]   m_axi_araddr,
  output logic [2:0]             m_axi_arprot,
  input  logic                   m_axi_rvalid,
  output logic                   m_axi_rready,
  input  logic [DataWidth-1:0]   m_axi_rdata,
  input  logic [1:0]             m_axi_rresp
);

  localparam int unsigned BeWidth = DataWidth / 8;

  typedef enum logic [2:0] {IDLE, WR, WB, RD_AR, RD_R, RESP} state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q;
  logic [BeWidth-1:0]     be_q;
  logic [DataWidth-1:0]   wdata_q;
  logic [DataWidth-1:0]   rdata_q;
  logic                   we_q;
  logic                   error_q;
  logic                   aw_done_q;
  logic                   w_done_q;
  logic                   aw_hs, w_hs, b_hs, r_hs;
  logic                   timeout;

  assign s_mem_gnt = s_mem_req && (state_q == IDLE || state_q == RESP);

  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid  && m_axi_wready;
  assign b_hs  = m_axi_bvalid  && m_axi_bready;
  assign r_hs  = m_axi_rvalid  && m_axi_rready;

`ifdef BRIDGE_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);

  logic [CntWidth-1:0] cnt_q;
  logic                busy;

  assign busy    = (state_q == WR) || (state_q == WB) || (state_q == RD_AR) || (state_q == RD_R);
  assign timeout = busy && (cnt_q == CntWidth'(TimeoutCycles - 1));

  // Watchdog: counts cycles spent in the current busy state, cleared on any state change
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if (busy) begin
      cnt_q <= cnt_q + CntWidth'(1);
    end
  end
`else
  logic unused_timeout_cfg;
  assign timeout            = 1'b0;
  assign unused_timeout_cfg = ^TimeoutCycles;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the watchdog overrides any pending AXI phase
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (s_mem_gnt) state_d = s_mem_we ? WR : RD_AR;
      WR:      if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WB;
      WB:      if (m_axi_bvalid) state_d = RESP;
      RD_AR:   if (m_axi_arready) state_d = RD_R;
      RD_R:    if (m_axi_rvalid) state_d = RESP;
      RESP:    state_d = s_mem_gnt ? (s_mem_we ? WR : RD_AR) : IDLE;
      default: state_d = IDLE;
    endcase
    if (timeout) begin
      state_d = RESP;
    end
  end

  // Output decode from the state and handshake-tracking flops
  always_comb begin
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    s_mem_valid   = 1'b0;
    unique case (state_q)
      WR: begin
        m_axi_awvalid = we_q && !aw_done_q;
        m_axi_wvalid  = we_q && !w_done_q;
      end
      WB:      m_axi_bready  = 1'b1;
      RD_AR:   m_axi_arvalid = 1'b1;
      RD_R:    m_axi_rready  = 1'b1;
      RESP:    s_mem_valid   = 1'b1;
      default: ;
    endcase
  end

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = be_q;
  assign s_mem_rdata  = rdata_q;
  assign s_mem_error  = error_q;

  // Request capture, AW/W completion flags and response capture
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (s_mem_gnt) begin
        addr_q    <= s_mem_addr;
        be_q      <= s_mem_be;
        wdata_q   <= s_mem_wdata;
        we_q      <= s_mem_we;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        if (aw_hs) aw_done_q <= 1'b1;
        if (w_hs)  w_done_q  <= 1'b1;
      end
      if (timeout) begin
        error_q <= 1'b1;
        rdata_q <= '0;
      end else if (b_hs) begin
        error_q <= (m_axi_bresp != 2'b00);
        rdata_q <= '0;
      end else if (r_hs) begin
        error_q <= (m_axi_rresp != 2'b00);
        rdata_q <= m_axi_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_to_axilite_bridge.sv
// Self-checking bench for mem_to_axilite_bridge: directed cases plus
// randomized transactions against a per-transaction slave/reference model.
module tb_mem_to_axilite_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we, gnt, valid, err;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, araddr, wdata_ax, rdata_ax;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_to_axilite_bridge #(
    .AddrWidth(32),
    .DataWidth(32),
    .TimeoutCycles(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_mem_req(req), .s_mem_gnt(gnt), .s_mem_addr(addr), .s_mem_we(we),
    .s_mem_be(be), .s_mem_wdata(wdata), .s_mem_valid(valid),
    .s_mem_rdata(rdata), .s_mem_error(err),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata_ax), .m_axi_wstrb(wstrb),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr), .m_axi_arprot(arprot),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata_ax), .m_axi_rresp(rresp)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic slave_idle();
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; rvalid = 1'b0; bresp = 2'b00; rresp = 2'b00; rdata_ax = '0;
  endtask

  // Slave data for the back-to-back test, a pure function of the address
  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return a * 32'd3 + 32'd1;
  endfunction

  // One complete transaction from IDLE; called at posedge+1.
  // Latencies: ready rises aw_lat/w_lat cycles after the request phase starts,
  // B/R valid appears rsp_lat cycles after the address/data phase completes.
  task automatic do_txn(input bit t_we, input logic [31:0] t_addr, input logic [3:0] t_be,
                        input logic [31:0] t_wd, input int aw_lat, input int w_lat,
                        input int rsp_lat, input logic [1:0] t_resp, input logic [31:0] t_rd,
                        input bit chk_lat);
    bit aw_done = 0, w_done = 0, ar_done = 0, b_arm = 0, b_done = 0, r_arm = 0, got = 0;
    int b_wait = 0, r_wait = 0, n = 0;
    req = 1'b1; we = t_we; addr = t_addr; be = t_be; wdata = t_wd;
    #1;
    check("gnt_idle", gnt, 1);
    while (!got && n < 200) begin
      @(posedge clk); #1; n++;
      req = 1'b0; we = $urandom; addr = $urandom; wdata = $urandom; be = 4'($urandom);
      awready = (n >= 1 + aw_lat);
      wready  = (n >= 1 + w_lat);
      arready = (n >= 1 + aw_lat);
      bvalid = 1'b0; rvalid = 1'b0;
      bresp = 2'($urandom); rresp = 2'($urandom); rdata_ax = $urandom;
      if (b_arm) begin
        if (b_wait == 0) begin bvalid = 1'b1; bresp = t_resp; end
        else b_wait--;
      end
      if (r_arm) begin
        if (r_wait == 0) begin rvalid = 1'b1; rresp = t_resp; rdata_ax = t_rd; end
        else r_wait--;
      end
      #1;
      check("gnt_busy", gnt, 0);
      if (valid) begin
        got = 1;
        check("rdata", rdata, t_we ? 32'h0 : t_rd);
        check("error", err, t_resp != 2'b00);
        if (chk_lat) check("latency", n, 3);
      end else begin
        check("awvalid", awvalid, t_we && !aw_done);
        check("wvalid", wvalid, t_we && !w_done);
        check("arvalid", arvalid, !t_we && !ar_done);
        if (awvalid && awready) begin
          check("awaddr", awaddr, t_addr);
          check("awprot", awprot, 0);
          aw_done = 1;
        end
        if (wvalid && wready) begin
          check("wdata", wdata_ax, t_wd);
          check("wstrb", wstrb, t_be);
          w_done = 1;
        end
        if (arvalid && arready) begin
          check("araddr", araddr, t_addr);
          check("arprot", arprot, 0);
          ar_done = 1; r_arm = 1; r_wait = rsp_lat;
        end
        if (bvalid && bready) begin b_arm = 0; b_done = 1; end
        if (rvalid && rready) r_arm = 0;
        if (t_we && aw_done && w_done && !b_arm && !b_done) begin
          b_arm = 1; b_wait = rsp_lat;
        end
      end
    end
    if (!got) check("resp_timeout", 0, 1);
    @(posedge clk); #1;
    slave_idle();
    check("valid_pulse", valid, 0);
  endtask

  initial begin
    logic [31:0] qaddr[$];
    logic [31:0] a, r_d;
    bit r_pend, adv;
    int gi, vi, n;

    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
    slave_idle();
    repeat (3) @(posedge clk);
    #1;
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_rready", rready, 0);
    check("rst_valid", valid, 0);
    check("rst_error", err, 0);
    check("rst_rdata", rdata, 0);
    check("rst_awaddr", awaddr, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    do_txn(0, 32'h0000_1000, 4'hF, 32'h0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF, 1);
    do_txn(1, 32'h0000_2004, 4'b0011, 32'h1234_5678, 0, 5, 0, 2'b00, 32'h0, 0);
    do_txn(0, 32'h0000_3000, 4'hF, 32'h0, 1, 1, 2, 2'b10, 32'hCAFE_F00D, 0);
    do_txn(1, 32'h0000_4002, 4'b1100, 32'hA5A5_5A5A, 3, 0, 1, 2'b11, 32'h0, 0);
    do_txn(1, 32'h0000_5000, 4'hF, 32'h0BAD_F00D, 0, 0, 0, 2'b00, 32'h0, 1);
`ifndef BRIDGE_TIMEOUT_EN
    do_txn(0, 32'h0000_6000, 4'hF, 32'h0, 0, 0, 40, 2'b00, 32'h7777_1111, 0);
`endif

    // Randomized transactions; every fourth one uses a zero-wait slave
    for (int i = 0; i < 24; i++) begin
      if (i % 4 == 0)
        do_txn(1'($urandom), $urandom, 4'($urandom), $urandom, 0, 0, 0,
               2'($urandom), $urandom, 1);
      else
        do_txn(1'($urandom), $urandom, 4'($urandom), $urandom, $urandom_range(0, 6),
               $urandom_range(0, 6), $urandom_range(0, 6), 2'($urandom), $urandom, 0);
    end

    // Back-to-back reads with continuous request and a zero-wait slave
    gi = 0; vi = 0; r_pend = 0; r_d = '0; adv = 0;
    a = $urandom;
    req = 1'b1; we = 1'b0; addr = a; be = 4'hF;
    for (n = 0; n < 15; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      if (adv) begin
        adv = 0;
        if (gi < 4) addr = $urandom;
        else req = 1'b0;
      end
      arready = 1'b1; rvalid = r_pend; rdata_ax = r_d; rresp = 2'b00;
      #1;
      if (gnt) begin
        check("b2b_gnt_cycle", n, 3 * gi);
        qaddr.push_back(addr);
        gi++; adv = 1;
      end
      if (valid) begin
        check("b2b_valid_cycle", n, 3 * vi + 3);
        if (qaddr.size() > 0) check("b2b_rdata", rdata, slave_data(qaddr.pop_front()));
        else check("b2b_extra_valid", 1, 0);
        check("b2b_error", err, 0);
        vi++;
      end
      if (rvalid && rready) r_pend = 0;
      if (arvalid && arready) begin r_pend = 1; r_d = slave_data(araddr); end
    end
    check("b2b_grants", gi, 4);
    check("b2b_valids", vi, 4);
    req = 1'b0;
    @(posedge clk); #1;
    slave_idle();

    // Reset while waiting in WB
    req = 1'b1; we = 1'b1; addr = 32'h0000_9000; be = 4'hF; wdata = 32'h1111_2222;
    n = 0;
    @(posedge clk); #1;
    req = 1'b0; awready = 1'b1; wready = 1'b1;
    while (!bready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("reach_wb", bready, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_awvalid", awvalid, 0);
    check("mid_rst_wvalid", wvalid, 0);
    check("mid_rst_arvalid", arvalid, 0);
    check("mid_rst_bready", bready, 0);
    check("mid_rst_rready", rready, 0);
    check("mid_rst_valid", valid, 0);
    rst_n = 1'b1;
    slave_idle();
    req = 1'b1; we = 1'b0;
    #1;
    check("mid_rst_idle_gnt", gnt, 1);
    req = 1'b0;
    @(posedge clk); #1;

`ifdef BRIDGE_TIMEOUT_EN
    // Read to an unresponsive slave: AR never accepted
    req = 1'b1; we = 1'b0; addr = 32'h0000_A000;
    n = 0;
    @(posedge clk); #1; n++;
    req = 1'b0;
    while (!valid && n < 100) begin
      check("to_arvalid", arvalid, 1);
      @(posedge clk); #1; n++;
    end
    check("to_cycle", n, 17);
    check("to_error", err, 1);
    check("to_rdata", rdata, 0);
    check("to_arvalid_drop", arvalid, 0);
    @(posedge clk); #1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
